// File: rtl/instr_issue_if.sv
// Program-load, start and issue signals between a controller and instr_issue.
// Controller side is the master; the issue block is the slave.
interface instr_issue_if #(
  parameter int AW = 4
);
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrData;
  logic          Start;
  logic [31:0]   Opcode;
  logic [AW-1:0] PC;
  logic          Stall;
  logic          Busy;
  logic          Done;

  modport master (
    output WrEn, WrAddr, WrData, Start,
    input  Opcode, PC, Stall, Busy, Done
  );

  modport slave (
    input  WrEn, WrAddr, WrData, Start,
    output Opcode, PC, Stall, Busy, Done
  );
endinterface

// File: rtl/instr_issue.sv
// In-order issue with load-use/RAW bubble insertion; first Opcode one edge after Start.
// No backpressure: issues one word or bubble per RUN cycle, writes ignored while busy.
module instr_issue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clk,
  input  logic          Re,
  instr_issue_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0]    OP_R  = 6'h00;
  localparam logic [5:0]    OP_LW = 6'h23;
  localparam logic [5:0]    OP_SW = 6'h2B;
  localparam logic [31:0]   HALT  = 32'hFFFF_FFFF;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state;
  logic          drain_cnt;
  logic [31:0]   opcode_q;
  logic [AW-1:0] pc_q;
  logic          stall_q;
  logic [4:0]    h0_dest, h1_dest;
  logic          h0_ld, h1_ld;

  logic [31:0] cur;
  logic [5:0]  op;
  logic [4:0]  rs, rt, dest;
  logic        use_rt, is_ld, is_halt, rs_haz, rt_haz, hazard, idle_like;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign bus.Opcode = opcode_q;
  assign bus.PC     = pc_q;
  assign bus.Stall  = stall_q;
  assign bus.Busy   = (state == RUN) || (state == DRAIN);
  assign bus.Done   = (state == DONE);

  // Program store is deliberately outside the reset domain.
  always_ff @(posedge Clk) begin
    if (bus.WrEn && idle_like) begin
      mem[bus.WrAddr] <= bus.WrData;
    end
  end

  always_comb begin
    cur     = mem[pc_q];
    op      = cur[31:26];
    rs      = cur[25:21];
    rt      = cur[20:16];
    is_halt = (cur == HALT);
    is_ld   = (op == OP_LW);
    use_rt  = (op == OP_R) || (op == OP_SW);
    dest    = 5'd0;
    if (op == OP_R) begin
      dest = cur[15:11];
    end else if (is_ld) begin
      dest = rt;
    end
    // A result two slots back is only still in flight when it came from a load.
    rs_haz = (rs != 5'd0) && ((rs == h0_dest) || (h1_ld && (rs == h1_dest)));
    rt_haz = use_rt && (rt != 5'd0) && ((rt == h0_dest) || (h1_ld && (rt == h1_dest)));
    hazard = rs_haz || rt_haz;
  end

  always_ff @(posedge Clk or posedge Re) begin
    if (Re) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      opcode_q  <= 32'h0;
      pc_q      <= '0;
      stall_q   <= 1'b0;
      h0_dest   <= 5'd0;
      h0_ld     <= 1'b0;
      h1_dest   <= 5'd0;
      h1_ld     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          h1_dest <= h0_dest;
          h1_ld   <= h0_ld;
          if (is_halt) begin
            opcode_q  <= 32'h0;
            stall_q   <= 1'b0;
            h0_dest   <= 5'd0;
            h0_ld     <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else if (hazard) begin
            opcode_q <= 32'h0;
            stall_q  <= 1'b1;
            h0_dest  <= 5'd0;
            h0_ld    <= 1'b0;
          end else begin
            opcode_q <= cur;
            stall_q  <= 1'b0;
            h0_dest  <= dest;
            h0_ld    <= is_ld;
            pc_q     <= pc_q + AW'(1);
            if (pc_q == LAST) begin
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          opcode_q <= 32'h0;
          stall_q  <= 1'b0;
          h1_dest  <= h0_dest;
          h1_ld    <= h0_ld;
          h0_dest  <= 5'd0;
          h0_ld    <= 1'b0;
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          opcode_q <= 32'h0;
          stall_q  <= 1'b0;
          if (bus.Start) begin
            pc_q    <= '0;
            h0_dest <= 5'd0;
            h0_ld   <= 1'b0;
            h1_dest <= 5'd0;
            h1_ld   <= 1'b0;
            state   <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: vector table for the hazard program plus corner-case sequences.
module tb_instr_issue;

  logic Clk = 1'b0;
  logic Re  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_issue_if #(.AW(4)) bus ();

  instr_issue #(.DEPTH(16), .AW(4)) dut (
    .Clk (Clk),
    .Re  (Re),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        start;
    logic [31:0] opc;
    logic        stall;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [38:0] got();
    return {bus.Opcode, bus.Stall, bus.PC, bus.Busy, bus.Done};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={opc,stall,pc,busy,done}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d);
    bus.WrEn   = 1'b1;
    bus.WrAddr = a;
    bus.WrData = d;
    tick();
    bus.WrEn   = 1'b0;
  endtask

  task automatic start_run();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.Done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, {38'd0, bus.Done}, 39'd1);
  endtask

  initial begin
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.Start  = 1'b0;

    vecs[0]  = {1'b1, 32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = {1'b0, 32'h8C0A_0008, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[2]  = {1'b0, 32'h8C0C_0010, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[3]  = {1'b1, 32'h0000_0000, 1'b1, 4'd2, 1'b1, 1'b0};
    vecs[4]  = {1'b0, 32'h0000_0000, 1'b1, 4'd2, 1'b1, 1'b0};
    vecs[5]  = {1'b0, 32'h014C_7020, 1'b0, 4'd3, 1'b1, 1'b0};
    vecs[6]  = {1'b0, 32'h0000_0000, 1'b1, 4'd3, 1'b1, 1'b0};
    vecs[7]  = {1'b0, 32'hAC0E_000E, 1'b0, 4'd4, 1'b1, 1'b0};
    vecs[8]  = {1'b0, 32'h8C10_000E, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[9]  = {1'b0, 32'h0000_0000, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[10] = {1'b1, 32'h0000_0000, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[11] = {1'b0, 32'h0000_0000, 1'b0, 4'd5, 1'b0, 1'b1};
    vecs[12] = {1'b0, 32'h0000_0000, 1'b0, 4'd5, 1'b0, 1'b1};

    // Reset state
    #1 Re = 1'b1;
    #2 check("reset_state", got(), 39'd0);
    @(negedge Clk);
    Re = 1'b0;

    // Hazard program; halt written on the same edge as Start
    write_word(4'd0, 32'h8C0A_0008);
    write_word(4'd1, 32'h8C0C_0010);
    write_word(4'd2, 32'h014C_7020);
    write_word(4'd3, 32'hAC0E_000E);
    write_word(4'd4, 32'h8C10_000E);
    for (int i = 0; i < 13; i++) begin
      bus.Start = vecs[i].start;
      if (i == 0) begin
        bus.WrEn   = 1'b1;
        bus.WrAddr = 4'd5;
        bus.WrData = 32'hFFFF_FFFF;
      end
      tick();
      bus.WrEn  = 1'b0;
      bus.Start = 1'b0;
      check($sformatf("prog1_cyc%0d", i), got(),
            {vecs[i].opc, vecs[i].stall, vecs[i].pc, vecs[i].busy, vecs[i].done});
    end

    // Independent R-types, then sw/lw sharing rt: no bubbles anywhere
    write_word(4'd0, 32'h0043_0820);
    write_word(4'd1, 32'h00A6_2020);
    write_word(4'd2, 32'hAC07_0000);
    write_word(4'd3, 32'h8C07_0004);
    write_word(4'd4, 32'hFFFF_FFFF);
    start_run();
    tick(); check("rtype_a", got(), {32'h0043_0820, 1'b0, 4'd1, 1'b1, 1'b0});
    tick(); check("rtype_b", got(), {32'h00A6_2020, 1'b0, 4'd2, 1'b1, 1'b0});
    tick(); check("sw_issue", got(), {32'hAC07_0000, 1'b0, 4'd3, 1'b1, 1'b0});
    tick(); check("lw_after_sw", got(), {32'h8C07_0004, 1'b0, 4'd4, 1'b1, 1'b0});
    wait_done("prog2_done");

    // 16 non-halt words: PC wraps, then DRAIN and DONE
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 32'h3400_0000 | i);
    end
    start_run();
    check("wrap_start", got(), {32'h0, 1'b0, 4'd0, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("wrap_issue%0d", i), got(),
            {32'h3400_0000 | i, 1'b0, 4'((i + 1) % 16), 1'b1, 1'b0});
    end
    tick(); check("wrap_drain2", got(), {32'h0, 1'b0, 4'd0, 1'b1, 1'b0});
    tick(); check("wrap_done", got(), {32'h0, 1'b0, 4'd0, 1'b0, 1'b1});

    // Asynchronous reset mid-RUN; Start ignored while reset is held
    start_run();
    for (int i = 0; i < 5; i++) tick();
    #2 Re = 1'b1;
    #1 check("async_reset", got(), 39'd0);
    bus.Start = 1'b1;
    tick();
    check("start_in_reset", got(), 39'd0);
    Re = 1'b0;
    tick();
    bus.Start = 1'b0;
    tick(); check("rerun_w0", got(), {32'h3400_0000, 1'b0, 4'd1, 1'b1, 1'b0});
    tick(); check("rerun_w1", got(), {32'h3400_0001, 1'b0, 4'd2, 1'b1, 1'b0});

    // Writes during RUN must not land
    bus.WrEn = 1'b1;
    for (int i = 2; i < 16; i++) begin
      bus.WrAddr = 4'(i + 3);
      bus.WrData = 32'hFFFF_FFFF;
      tick();
      if (i == 6) bus.WrEn = 1'b0;
      check($sformatf("run_write_w%0d", i), got(),
            {32'h3400_0000 | i, 1'b0, 4'((i + 1) % 16), 1'b1, 1'b0});
    end
    bus.WrEn = 1'b0;
    wait_done("run_write_done");
    start_run();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rerun2_w%0d", i), got(),
            {32'h3400_0000 | i, 1'b0, 4'(i + 1), 1'b1, 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
